// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Turns decoded Minisys/MIPS instruction fields into 32-bit
//               instruction words and writes them one after another into
//               instruction memory. Used for boot loading and for building
//               self-test programs.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [4:0]        i_cmd_op,
  input  logic [4:0]        i_cmd_rs,
  input  logic [4:0]        i_cmd_rt,
  input  logic [4:0]        i_cmd_rd,
  input  logic [4:0]        i_cmd_shamt,
  input  logic [15:0]       i_cmd_imm,
  input  logic [25:0]       i_cmd_target,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wdata,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_done,
  output logic              o_err
);

  // Loader states
  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_LOAD  = 2'd1;
  localparam logic [1:0] C_ST_WRITE = 2'd2;
  localparam logic [1:0] C_ST_DONE  = 2'd3;

  // Command mnemonic codes
  localparam logic [4:0] C_OP_ADD   = 5'd0;
  localparam logic [4:0] C_OP_ADDU  = 5'd1;
  localparam logic [4:0] C_OP_SUB   = 5'd2;
  localparam logic [4:0] C_OP_SUBU  = 5'd3;
  localparam logic [4:0] C_OP_AND   = 5'd4;
  localparam logic [4:0] C_OP_OR    = 5'd5;
  localparam logic [4:0] C_OP_XOR   = 5'd6;
  localparam logic [4:0] C_OP_NOR   = 5'd7;
  localparam logic [4:0] C_OP_SLT   = 5'd8;
  localparam logic [4:0] C_OP_SLTU  = 5'd9;
  localparam logic [4:0] C_OP_SLL   = 5'd10;
  localparam logic [4:0] C_OP_SRL   = 5'd11;
  localparam logic [4:0] C_OP_SRA   = 5'd12;
  localparam logic [4:0] C_OP_SLLV  = 5'd13;
  localparam logic [4:0] C_OP_SRLV  = 5'd14;
  localparam logic [4:0] C_OP_SRAV  = 5'd15;
  localparam logic [4:0] C_OP_JR    = 5'd16;
  localparam logic [4:0] C_OP_ADDI  = 5'd17;
  localparam logic [4:0] C_OP_ADDIU = 5'd18;
  localparam logic [4:0] C_OP_SLTI  = 5'd19;
  localparam logic [4:0] C_OP_SLTIU = 5'd20;
  localparam logic [4:0] C_OP_ANDI  = 5'd21;
  localparam logic [4:0] C_OP_ORI   = 5'd22;
  localparam logic [4:0] C_OP_XORI  = 5'd23;
  localparam logic [4:0] C_OP_LUI   = 5'd24;
  localparam logic [4:0] C_OP_LW    = 5'd25;
  localparam logic [4:0] C_OP_SW    = 5'd26;
  localparam logic [4:0] C_OP_BEQ   = 5'd27;
  localparam logic [4:0] C_OP_BNE   = 5'd28;
  localparam logic [4:0] C_OP_J     = 5'd29;
  localparam logic [4:0] C_OP_JAL   = 5'd30;
  localparam logic [4:0] C_OP_END   = 5'd31;

  // Instruction formats
  localparam logic [1:0] C_FMT_R = 2'd0;
  localparam logic [1:0] C_FMT_I = 2'd1;
  localparam logic [1:0] C_FMT_J = 2'd2;

  // Word count at which memory is full; one more word would overflow
  localparam logic [ADDR_W:0]   C_CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_hs;
  logic [1:0]        w_fmt;
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic              w_shift_imm;
  logic [4:0]        w_rs_f;
  logic [4:0]        w_rt_f;
  logic [4:0]        w_rd_f;
  logic [4:0]        w_sh_f;
  logic [31:0]       w_word;

  assign w_hs = i_cmd_valid & o_cmd_ready;

  // Select format, primary opcode and funct code for the mnemonic
  always_comb begin
    w_fmt    = C_FMT_R;
    w_opcode = 6'h00;
    w_funct  = 6'h00;
    case (i_cmd_op)
      C_OP_ADD:   w_funct = 6'h20;
      C_OP_ADDU:  w_funct = 6'h21;
      C_OP_SUB:   w_funct = 6'h22;
      C_OP_SUBU:  w_funct = 6'h23;
      C_OP_AND:   w_funct = 6'h24;
      C_OP_OR:    w_funct = 6'h25;
      C_OP_XOR:   w_funct = 6'h26;
      C_OP_NOR:   w_funct = 6'h27;
      C_OP_SLT:   w_funct = 6'h2A;
      C_OP_SLTU:  w_funct = 6'h2B;
      C_OP_SLL:   w_funct = 6'h00;
      C_OP_SRL:   w_funct = 6'h02;
      C_OP_SRA:   w_funct = 6'h03;
      C_OP_SLLV:  w_funct = 6'h04;
      C_OP_SRLV:  w_funct = 6'h06;
      C_OP_SRAV:  w_funct = 6'h07;
      C_OP_JR:    w_funct = 6'h08;
      C_OP_ADDI:  begin w_fmt = C_FMT_I; w_opcode = 6'h08; end
      C_OP_ADDIU: begin w_fmt = C_FMT_I; w_opcode = 6'h09; end
      C_OP_SLTI:  begin w_fmt = C_FMT_I; w_opcode = 6'h0A; end
      C_OP_SLTIU: begin w_fmt = C_FMT_I; w_opcode = 6'h0B; end
      C_OP_ANDI:  begin w_fmt = C_FMT_I; w_opcode = 6'h0C; end
      C_OP_ORI:   begin w_fmt = C_FMT_I; w_opcode = 6'h0D; end
      C_OP_XORI:  begin w_fmt = C_FMT_I; w_opcode = 6'h0E; end
      C_OP_LUI:   begin w_fmt = C_FMT_I; w_opcode = 6'h0F; end
      C_OP_LW:    begin w_fmt = C_FMT_I; w_opcode = 6'h23; end
      C_OP_SW:    begin w_fmt = C_FMT_I; w_opcode = 6'h2B; end
      C_OP_BEQ:   begin w_fmt = C_FMT_I; w_opcode = 6'h04; end
      C_OP_BNE:   begin w_fmt = C_FMT_I; w_opcode = 6'h05; end
      C_OP_J:     begin w_fmt = C_FMT_J; w_opcode = 6'h02; end
      C_OP_JAL:   begin w_fmt = C_FMT_J; w_opcode = 6'h03; end
      default:    begin w_fmt = C_FMT_R; w_opcode = 6'h00; w_funct = 6'h00; end
    endcase
  end

  // Force the fields the decoder treats as don't-care to zero so every
  // emitted word is the canonical encoding
  always_comb begin
    w_shift_imm = (i_cmd_op == C_OP_SLL) || (i_cmd_op == C_OP_SRL) ||
                  (i_cmd_op == C_OP_SRA);
    w_rs_f = (w_shift_imm || (i_cmd_op == C_OP_LUI)) ? 5'd0 : i_cmd_rs;
    w_rt_f = (i_cmd_op == C_OP_JR) ? 5'd0 : i_cmd_rt;
    w_rd_f = (i_cmd_op == C_OP_JR) ? 5'd0 : i_cmd_rd;
    w_sh_f = w_shift_imm ? i_cmd_shamt : 5'd0;
  end

  // Pack the fields according to the instruction format
  always_comb begin
    w_word = 32'h0000_0000;
    case (w_fmt)
      C_FMT_R: w_word = {6'h00, w_rs_f, w_rt_f, w_rd_f, w_sh_f, w_funct};
      C_FMT_I: w_word = {w_opcode, w_rs_f, i_cmd_rt, i_cmd_imm};
      C_FMT_J: w_word = {w_opcode, i_cmd_target};
      default: w_word = 32'h0000_0000;
    endcase
  end

  // Load sequencer: accept a command, write it for one cycle, advance the address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= C_ST_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_wdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (i_start) begin
      // start wins over any handshake or pending write this cycle
      r_state <= C_ST_LOAD;
      r_addr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          r_state <= C_ST_IDLE;
        end
        C_ST_LOAD: begin
          if (w_hs) begin
            if (i_cmd_op == C_OP_END) begin
              r_state <= C_ST_DONE;
            end else if (r_count == C_CAP) begin
              r_err   <= 1'b1;
              r_state <= C_ST_DONE;
            end else begin
              r_wdata <= w_word;
              r_state <= C_ST_WRITE;
            end
          end
        end
        C_ST_WRITE: begin
          r_addr  <= r_addr + C_ADDR_ONE;
          r_count <= r_count + C_CNT_ONE;
          r_state <= C_ST_LOAD;
        end
        C_ST_DONE: begin
          r_state <= C_ST_DONE;
        end
        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so reset drops the strobe at once
  assign o_cmd_ready  = (r_state == C_ST_LOAD);
  assign o_im_we      = (r_state == C_ST_WRITE);
  assign o_done       = (r_state == C_ST_DONE);
  assign o_err        = r_err;
  assign o_im_addr    = r_addr;
  assign o_im_wdata   = r_wdata;
  assign o_word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Self-checking bench. A field-table encoder model and a queue
//               of expected writes are compared against two instances
//               (default width and a 4-word memory for overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        valid_a, valid_b;
  logic [4:0]  c_op, c_rs, c_rt, c_rd, c_sh;
  logic [15:0] c_imm;
  logic [25:0] c_tg;

  logic        ready_a, we_a, done_a, err_a;
  logic [13:0] addr_a;
  logic [31:0] wdata_a;
  logic [14:0] cnt_a;
  logic        ready_b, we_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

  instr_encoder_loader #(.ADDR_W(14)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cmd_valid(valid_a),
    .o_cmd_ready(ready_a), .i_cmd_op(c_op), .i_cmd_rs(c_rs), .i_cmd_rt(c_rt),
    .i_cmd_rd(c_rd), .i_cmd_shamt(c_sh), .i_cmd_imm(c_imm), .i_cmd_target(c_tg),
    .o_im_we(we_a), .o_im_addr(addr_a), .o_im_wdata(wdata_a),
    .o_word_count(cnt_a), .o_done(done_a), .o_err(err_a)
  );

  instr_encoder_loader #(.ADDR_W(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cmd_valid(valid_b),
    .o_cmd_ready(ready_b), .i_cmd_op(c_op), .i_cmd_rs(c_rs), .i_cmd_rt(c_rt),
    .i_cmd_rd(c_rd), .i_cmd_shamt(c_sh), .i_cmd_imm(c_imm), .i_cmd_target(c_tg),
    .o_im_we(we_b), .o_im_addr(addr_b), .o_im_wdata(wdata_b),
    .o_word_count(cnt_b), .o_done(done_b), .o_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  logic [5:0] FN  [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  logic [5:0] OPC [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  function automatic logic [31:0] enc(input logic [4:0] op, rs, rt, rd, sh,
                                      input logic [15:0] imm, input logic [25:0] tg);
    int idx;
    bit shf;
    idx = int'(op);
    if (idx <= 16) begin
      shf = (idx >= 10 && idx <= 12);
      if (shf) rs = 5'd0; else sh = 5'd0;
      if (idx == 16) begin rt = 5'd0; rd = 5'd0; end
      return {6'h00, rs, rt, rd, sh, FN[idx]};
    end else if (idx >= 29) begin
      return {OPC[idx-17], tg};
    end else begin
      if (idx == 24) rs = 5'd0;
      return {OPC[idx-17], rs, rt, imm};
    end
  endfunction

  logic [45:0] q [2][$];      // {addr(14), data(32)} expected writes
  int          maddr [2];
  int          mcnt  [2];
  bit          mdone [2];
  bit          merr  [2];
  int          cap   [2] = '{16384, 4};
  int          we_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      q[w].delete();
      maddr[w] = 0; mcnt[w] = 0; mdone[w] = 0; merr[w] = 0;
    end
  endtask

  // ---------------- compare process ----------------
  bit prev_we_a = 0, prev_we_b = 0;
  always @(negedge clk) begin
    logic [45:0] e;
    if (rst_n) begin
      if (we_a) begin
        chk("we_a_single", {63'd0, prev_we_a}, 64'd0);
        chk("ready_a_low_in_write", {63'd0, ready_a}, 64'd0);
        if (q[0].size() == 0) chk("unexpected_write_a", 64'd1, 64'd0);
        else begin
          e = q[0].pop_front();
          chk("addr_a", {50'd0, addr_a}, {50'd0, e[45:32]});
          chk("wdata_a", {32'd0, wdata_a}, {32'd0, e[31:0]});
        end
        we_cyc.push_back(cyc);
      end
      if (we_b) begin
        chk("we_b_single", {63'd0, prev_we_b}, 64'd0);
        if (q[1].size() == 0) chk("unexpected_write_b", 64'd1, 64'd0);
        else begin
          e = q[1].pop_front();
          chk("addr_b", {62'd0, addr_b}, {50'd0, e[45:32]});
          chk("wdata_b", {32'd0, wdata_b}, {32'd0, e[31:0]});
        end
      end
    end
    prev_we_a = we_a;
    prev_we_b = we_b;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the handshake.
  task automatic send(input int w, input logic [4:0] op, rs, rt, rd, sh,
                      input logic [15:0] imm, input logic [25:0] tg, input bit keep);
    int n = 0;
    c_op = op; c_rs = rs; c_rt = rt; c_rd = rd; c_sh = sh; c_imm = imm; c_tg = tg;
    if (w == 0) valid_a = 1'b1; else valid_b = 1'b1;
    while (((w == 0) ? ready_a : ready_b) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("handshake_timeout", 64'd1, 64'd0);
    end else if (op == 5'd31) begin
      mdone[w] = 1;
    end else if (mcnt[w] == cap[w]) begin
      merr[w] = 1; mdone[w] = 1;
    end else begin
      q[w].push_back({14'(maddr[w]), enc(op, rs, rt, rd, sh, imm, tg)});
      maddr[w] = (maddr[w] + 1) % cap[w];
      mcnt[w]++;
    end
    @(posedge clk); #1;
    if (!keep) begin valid_a = 1'b0; valid_b = 1'b0; end
    @(negedge clk);
  endtask

  task automatic chk_a_zero(input string nm);
    chk({nm, "_ready"}, {63'd0, ready_a}, 64'd0);
    chk({nm, "_we"},    {63'd0, we_a},    64'd0);
    chk({nm, "_done"},  {63'd0, done_a},  64'd0);
    chk({nm, "_err"},   {63'd0, err_a},   64'd0);
    chk({nm, "_addr"},  {50'd0, addr_a},  64'd0);
    chk({nm, "_wdata"}, {32'd0, wdata_a}, 64'd0);
    chk({nm, "_count"}, {49'd0, cnt_a},   64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [4:0] k5;
    rst_n = 1'b0; start = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    c_op = 5'd0; c_rs = 5'd0; c_rt = 5'd0; c_rd = 5'd0; c_sh = 5'd0;
    c_imm = 16'd0; c_tg = 26'd0;
    model_clear();

    // Hand-computed encodings pin the model
    chk("pin_add",  {32'd0, enc(5'd0,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0)},   64'h00221820);
    chk("pin_lw",   {32'd0, enc(5'd25, 5'd29, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0)},   64'h8FA50010);
    chk("pin_sll",  {32'd0, enc(5'd10, 5'd7,  5'd4, 5'd4, 5'd2, 16'h0,    26'h0)},   64'h00042080);
    chk("pin_jal",  {32'd0, enc(5'd30, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h40)},  64'h0C000040);
    chk("pin_j",    {32'd0, enc(5'd29, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h100)}, 64'h08000100);
    chk("pin_beq",  {32'd0, enc(5'd27, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0)},   64'h1022FFFF);
    chk("pin_bne",  {32'd0, enc(5'd28, 5'd3,  5'd0, 5'd0, 5'd0, 16'h0004, 26'h0)},   64'h14600004);
    chk("pin_jr",   {32'd0, enc(5'd16, 5'd31, 5'd5, 5'd6, 5'd3, 16'h0,    26'h0)},   64'h03E00008);

    repeat (2) @(negedge clk);
    chk_a_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {63'd0, ready_a}, 64'd0);

    pulse_start();
    chk("start_ready", {63'd0, ready_a}, 64'd1);

    // Spot checks
    send(0, 5'd0,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,   0);
    @(negedge clk);
    chk("count_after_add", {49'd0, cnt_a}, 64'd1);
    send(0, 5'd25, 5'd29, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0,   0);
    send(0, 5'd10, 5'd7,  5'd4, 5'd4, 5'd2, 16'h0,    26'h0,   0);
    send(0, 5'd30, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h40,  0);
    send(0, 5'd29, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h100, 0);
    send(0, 5'd27, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0,   0);
    send(0, 5'd28, 5'd3,  5'd0, 5'd0, 5'd0, 16'h0004, 26'h0,   0);
    send(0, 5'd16, 5'd31, 5'd5, 5'd6, 5'd3, 16'h0,    26'h0,   0);

    // Every mnemonic with all fields non-zero
    for (int k = 0; k < 31; k++) begin
      k5 = 5'(k);
      send(0, k5, 5'(k * 3 + 1), k5 ^ 5'd21, 5'd31 - k5, k5 + 5'd7,
           16'(k * 1234 + 5), 26'(k * 99991 + 3), 0);
    end
    @(negedge clk);
    chk("count_after_all_ops", {49'd0, cnt_a}, 64'(mcnt[0]));

    // Back-to-back with cmd_valid held high
    pulse_start();
    base = we_cyc.size();
    send(0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1);
    send(0, 5'd5, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1);
    send(0, 5'd7, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 0);
    @(negedge clk);
    if (we_cyc.size() >= base + 3) begin
      chk("b2b_gap1", 64'(we_cyc[base+1] - we_cyc[base]), 64'd2);
      chk("b2b_gap2", 64'(we_cyc[base+2] - we_cyc[base+1]), 64'd2);
    end else begin
      chk("b2b_write_count", 64'(we_cyc.size() - base), 64'd3);
    end
    chk("b2b_count", {49'd0, cnt_a}, 64'd3);

    // END, then commands are ignored
    send(0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 0);
    chk("end_done",  {63'd0, done_a},  64'(mdone[0]));
    chk("end_ready", {63'd0, ready_a}, 64'd0);
    chk("end_count", {49'd0, cnt_a},   64'd3);
    chk("end_err",   {63'd0, err_a},   64'd0);
    c_op = 5'd0; valid_a = 1'b1;
    repeat (4) @(negedge clk);
    valid_a = 1'b0;
    chk("done_held", {63'd0, done_a}, 64'd1);

    pulse_start();
    chk("restart_done",  {63'd0, done_a},  64'd0);
    chk("restart_ready", {63'd0, ready_a}, 64'd1);
    chk("restart_count", {49'd0, cnt_a},   64'd0);
    send(0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0);
    @(negedge clk);

    // Overflow on the 4-word instance
    for (int k = 0; k < 4; k++)
      send(1, 5'd0, 5'(k), 5'(k + 1), 5'(k + 2), 5'd0, 16'h0, 26'h0, 0);
    @(negedge clk);
    chk("ovf_count_full", {61'd0, cnt_b}, 64'd4);
    chk("ovf_err_before", {63'd0, err_b}, 64'd0);
    send(1, 5'd0, 5'd9, 5'd9, 5'd9, 5'd0, 16'h0, 26'h0, 0);
    chk("ovf_err",   {63'd0, err_b},   64'(merr[1]));
    chk("ovf_done",  {63'd0, done_b},  64'(mdone[1]));
    chk("ovf_count", {61'd0, cnt_b},   64'd4);
    chk("ovf_ready", {63'd0, ready_b}, 64'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a WRITE cycle
    c_op = 5'd2; c_rs = 5'd1; c_rt = 5'd1; c_rd = 5'd1;
    valid_a = 1'b1;
    @(posedge clk); #2;
    valid_a = 1'b0;
    chk("pre_reset_we", {63'd0, we_a}, 64'd1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_a_zero("async_reset");
    chk("async_reset_err_b", {63'd0, err_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("queue_a_drained", 64'(q[0].size()), 64'd0);
    chk("queue_b_drained", 64'(q[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Overall watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
